// File: rtl/mldsa_pkg.sv
// mldsa_pkg: ML-DSA constants shared by the ExpandA controller, its address
// generator and the matrix interface, plus the controller state encoding.
package mldsa_pkg;
  localparam int Q       = 8380417;
  localparam int N       = 256;
  localparam int N_W     = 9;
  localparam int COEFF_W = 23;
  localparam int Z_W     = 24;
  localparam int ADDR_W  = 14;
  localparam int IDX_W   = 8;
  localparam int SEED_W  = 256;
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    COLLECT,
    NEXT,
    FINISH
  } state_t;
endpackage

// File: rtl/expand_a_ctrl_if.sv
// expand_a_ctrl_if: rejection-sampler handshake plus matrix RAM write port;
// master is the ExpandA controller, slave is the sampler/RAM side.
interface expand_a_ctrl_if;
  logic                                rej_start;
  logic [mldsa_pkg::SEED_W-1:0]        rej_rho;
  logic [mldsa_pkg::IDX_W-1:0]         rej_i;
  logic [mldsa_pkg::IDX_W-1:0]         rej_j;
  logic                                rej_done;
  logic [mldsa_pkg::Z_W-1:0]           rej_z;
  logic                                rej_z_valid;
  logic                                wr_en;
  logic [mldsa_pkg::ADDR_W-1:0]        wr_addr;
  logic [mldsa_pkg::COEFF_W-1:0]       wr_data;
  modport master (
    output rej_start, rej_rho, rej_i, rej_j, wr_en, wr_addr, wr_data,
    input  rej_done, rej_z, rej_z_valid
  );
  modport slave (
    input  rej_start, rej_rho, rej_i, rej_j, wr_en, wr_addr, wr_data,
    output rej_done, rej_z, rej_z_valid
  );
endinterface

// File: rtl/poly_addr_gen.sv
// poly_addr_gen: coefficient index n and matrix position (r, s) walked
// row-major, with the derived matrix RAM address (r*L + s)*256 + n.
module poly_addr_gen
  import mldsa_pkg::*;
#(
  parameter int K = 4,
  parameter int L = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              adv,
  output logic [N_W-1:0]    n,
  output logic [IDX_W-1:0]  s,
  output logic [IDX_W-1:0]  r,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);
  logic [N_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0] s_q, s_d;
  logic [IDX_W-1:0] r_q, r_d;
  logic             s_wrap;
  // (r, s) hold at the final polynomial so the indices stay valid in FINISH
  always_comb begin
    s_wrap = s_q == IDX_W'(L - 1);
    last   = s_wrap && r_q == IDX_W'(K - 1);
    n_d    = (clr || adv) ? '0 : inc ? n_q + 1'b1 : n_q;
    s_d    = clr ? '0 : (adv && !last) ? (s_wrap ? '0 : s_q + 1'b1) : s_q;
    r_d    = clr ? '0 : (adv && !last && s_wrap) ? r_q + 1'b1 : r_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n_q <= '0;
      s_q <= '0;
      r_q <= '0;
    end else begin
      n_q <= n_d;
      s_q <= s_d;
      r_q <= r_d;
    end
  assign n       = n_q;
  assign s       = s_q;
  assign r       = r_q;
  assign wr_addr = ADDR_W'((int'(r_q) * L + int'(s_q)) * N + int'(n_q));
endmodule

// File: rtl/expand_a_ctrl.sv
// expand_a_ctrl: sequences the K x L ExpandA polynomials through an external
// rejection sampler into matrix RAM. Define EXPAND_A_RANGE_CHECK_EN to flag
// coefficients that are not reduced mod q.
module expand_a_ctrl
  import mldsa_pkg::*;
#(
  parameter int K = 4,
  parameter int L = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEED_W-1:0] rho_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  expand_a_ctrl_if.master   bus
);
  state_t               state_q, state_d;
  logic [SEED_W-1:0]    rho_q, rho_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rej_start_q, rej_start_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [COEFF_W-1:0]   wr_data_q, wr_data_d;
  logic [N_W-1:0]       n;
  logic [N_W-1:0]       n_after;
  logic [IDX_W-1:0]     s;
  logic [IDX_W-1:0]     r;
  logic [ADDR_W-1:0]    addr;
  logic                 last;
  logic                 coll;
  logic                 accept;
  logic                 overflow;
  logic                 short_poly;
  logic                 bad_z;
  logic                 clr;
  logic                 adv;
  poly_addr_gen #(
    .K(K),
    .L(L)
  ) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .inc    (accept),
    .adv    (adv),
    .n      (n),
    .s      (s),
    .r      (r),
    .wr_addr(addr),
    .last   (last)
  );
  // a coefficient arriving with rej_done is counted before n is judged
  always_comb begin
    coll       = state_q == COLLECT;
    accept     = coll && bus.rej_z_valid && n != N_W'(N);
    overflow   = coll && bus.rej_z_valid && n == N_W'(N);
    n_after    = n + N_W'(accept);
    short_poly = coll && bus.rej_done && n_after != N_W'(N);
`ifdef EXPAND_A_RANGE_CHECK_EN
    bad_z      = accept && (bus.rej_z[Z_W-1] || bus.rej_z[COEFF_W-1:0] >= COEFF_W'(Q));
`else
    bad_z      = 1'b0;
`endif
    clr         = state_q == IDLE && start;
    adv         = state_q == NEXT;
    state_d     = clr ? LAUNCH
                : state_q == LAUNCH ? COLLECT
                : (coll && bus.rej_done) ? NEXT
                : state_q == NEXT ? (last ? FINISH : LAUNCH)
                : state_q == FINISH ? IDLE
                : state_q;
    rho_d       = clr ? rho_in : rho_q;
    busy_d      = state_d == LAUNCH || state_d == COLLECT || state_d == NEXT;
    done_d      = state_d == FINISH;
    rej_start_d = state_d == LAUNCH;
    err_d       = clr ? 1'b0 : err_q || overflow || short_poly || bad_z;
    wr_en_d     = accept;
    wr_addr_d   = accept ? addr : wr_addr_q;
    wr_data_d   = accept ? bus.rej_z[COEFF_W-1:0] : wr_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      rho_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rej_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rho_q       <= rho_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rej_start_q <= rej_start_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.rej_start = rej_start_q;
  assign bus.rej_rho   = rho_q;
  assign bus.rej_i     = s;
  assign bus.rej_j     = r;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_expand_a_ctrl.sv
// tb_expand_a_ctrl: directed runs of expand_a_ctrl against a behavioural
// rejection sampler emitting z = n (or a fixed z) per polynomial.
module tb_expand_a_ctrl;
  import mldsa_pkg::*;
`ifdef EXPAND_A_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] rho_in = '0;
  logic         busy, done, err;
  expand_a_ctrl_if bus();
  expand_a_ctrl #(.K(4), .L(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rho_in(rho_in),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int nv = 256, sp = -1, sn = 0, cnt_m = 0;
  bit done_same = 1'b0, use_fix = 1'b0;
  logic [23:0]  zfix = '0;
  logic [255:0] rho_exp = '0;
  int lc = 0, lc_base = 0, rho_bad = 0, rs_bad = 0;
  int li[256], lj[256];
  int wr_cnt = 0, wr_base = 0, data_bad = 0, addr_bad = 0;
  int done_cnt = 0, done_base = 0, t_first = 0, t_last = 0, cyc = 0;
  logic [13:0] addr255 = '0;
  logic [22:0] last_data = '0;
  // sampler model: reacts to rej_start, streams cnt_m values, then rej_done
  initial begin
    bus.rej_done = 1'b0;
    bus.rej_z_valid = 1'b0;
    bus.rej_z = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.rej_start) begin
        if (lc < 256) begin
          li[lc] = int'(bus.rej_i);
          lj[lc] = int'(bus.rej_j);
        end
        if (bus.rej_rho != rho_exp) rho_bad++;
        cnt_m = (lc - lc_base == sp) ? sn : nv;
        lc++;
        @(posedge clk); #1;
        if (bus.rej_start) rs_bad++;
        for (int k = 0; k < cnt_m && rst_n; k++) begin
          bus.rej_z_valid = 1'b1;
          bus.rej_z = use_fix ? zfix : 24'(k);
          bus.rej_done = done_same && k == cnt_m - 1;
          @(posedge clk); #1;
        end
        bus.rej_z_valid = 1'b0;
        bus.rej_done = 1'b0;
        if (!done_same && rst_n) begin
          bus.rej_done = 1'b1;
          @(posedge clk); #1;
          bus.rej_done = 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (bus.wr_en) begin
      if (bus.wr_data != (use_fix ? zfix[22:0] : 23'(bus.wr_addr[7:0]))) data_bad++;
      if (int'(bus.wr_addr) != wr_cnt - wr_base) addr_bad++;
      if (wr_cnt - wr_base == 0) t_first = cyc;
      if (wr_cnt - wr_base == 255) begin
        t_last = cyc;
        addr255 = bus.wr_addr;
      end
      last_data = bus.wr_data;
      wr_cnt++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic go(input logic [255:0] rho);
    @(negedge clk);
    rho_in = rho;
    rho_exp = rho;
    lc_base = lc;
    wr_base = wr_cnt;
    done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rho_in = ~rho;
  endtask
  task automatic wait_done(input string tag);
    for (int c = 0; c < 20000 && !done; c++) @(negedge clk);
    chk({tag, "_done"}, done, 1);
  endtask
  function automatic int order_bad();
    int m = 0;
    for (int p = lc_base; p < lc && p < 256; p++)
      if (li[p] != (p - lc_base) % 4 || lj[p] != (p - lc_base) / 4) m++;
    return m;
  endfunction
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rej_start", bus.rej_start, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rho", 64'(|bus.rej_rho), 0);
    rst_n = 1'b1;
    @(negedge clk);
    go({8{32'h1234_5678}});
    chk("busy_after_start", busy, 1);
    repeat (50) @(negedge clk);
    rho_in = {8{32'hdead_beef}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("run1");
    chk("busy_at_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("run1_launches", 64'(lc - lc_base), 16);
    chk("run1_order", 64'(order_bad()), 0);
    chk("run1_writes", 64'(wr_cnt - wr_base), 4096);
    chk("run1_addr", 64'(addr_bad), 0);
    chk("run1_data", 64'(data_bad), 0);
    chk("p0_span", 64'(t_last - t_first), 255);
    chk("p0_last_addr", 64'(addr255), 255);
    chk("run1_done_cnt", 64'(done_cnt - done_base), 1);
    chk("run1_err", err, 0);
    chk("run1_idle_busy", busy, 0);
    sp = 0;
    sn = 257;
    go({8{32'h0bad_f00d}});
    wait_done("over");
    repeat (3) @(negedge clk);
    chk("over_err", err, 1);
    chk("over_writes", 64'(wr_cnt - wr_base), 4096);
    chk("over_launches", 64'(lc - lc_base), 16);
    chk("over_done_cnt", 64'(done_cnt - done_base), 1);
    sn = 100;
    go({8{32'h0000_0100}});
    chk("err_clr_on_start", err, 0);
    wait_done("short");
    repeat (3) @(negedge clk);
    chk("short_err", err, 1);
    chk("short_writes", 64'(wr_cnt - wr_base), 3940);
    chk("short_next_i", 64'(li[lc_base + 1]), 1);
    chk("short_next_j", 64'(lj[lc_base + 1]), 0);
    chk("short_order", 64'(order_bad()), 0);
    sp = -1;
    done_same = 1'b1;
    go({8{32'h5555_aaaa}});
    wait_done("same");
    repeat (3) @(negedge clk);
    chk("same_err", err, 0);
    chk("same_writes", 64'(wr_cnt - wr_base), 4096);
    chk("same_data", 64'(data_bad), 0);
    done_same = 1'b0;
    sp = 0;
    sn = 100;
    go({8{32'hcafe_0001}});
    for (int c = 0; c < 20000 && !(bus.wr_en && bus.rej_i == 1 && bus.rej_j == 2); c++) @(negedge clk);
    chk("reach_2_1_i", 64'(bus.rej_i), 1);
    chk("reach_2_1_j", 64'(bus.rej_j), 2);
    chk("pre_rst_err", err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_rho", 64'(|bus.rej_rho), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - done_base), 0);
    sp = -1;
    go({8{32'hcafe_0002}});
    for (int c = 0; c < 100 && lc == lc_base; c++) @(negedge clk);
    chk("restart_i", 64'(li[lc_base]), 0);
    chk("restart_j", 64'(lj[lc_base]), 0);
    chk("restart_err", err, 0);
    wait_done("restart");
    repeat (3) @(negedge clk);
    chk("restart_writes", 64'(wr_cnt - wr_base), 4096);
    chk("restart_err_end", err, 0);
    use_fix = 1'b1;
    zfix = 24'd8380417;
    go({8{32'h7777_0001}});
    wait_done("range_q");
    repeat (3) @(negedge clk);
    chk("range_q_err", err, RC);
    chk("range_q_data", 64'(last_data), 8380417);
    zfix = 24'd8380416;
    go({8{32'h7777_0002}});
    wait_done("range_ok");
    repeat (3) @(negedge clk);
    chk("range_ok_err", err, 0);
    chk("range_ok_data", 64'(last_data), 8380416);
    chk("all_data", 64'(data_bad), 0);
    chk("rho_seen", 64'(rho_bad), 0);
    chk("rej_start_width", 64'(rs_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
